// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with write bypass, busy scoreboard and debug port
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic [DATA_W-1:0] rDataA,
   output logic [DATA_W-1:0] rDataB,
   output logic              busyA,
   output logic              busyB,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] W_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic              flush,
   output logic [ADDR_W:0]   busy_cnt,
   input  logic [ADDR_W-1:0] reg_checker,
   output logic [DATA_W-1:0] check_reg
);
   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [ADDR_W:0]   cnt_nxt;
   logic              wr_ok;
   logic              iss_ok;

   assign wr_ok  = RegWrite && (rd != '0);
   assign iss_ok = issue_en && (issue_rd != '0);

   assign rDataA = (rs1 == '0) ? '0 :
                   (BYPASS && wr_ok && (rd == rs1)) ? W_data : regs[rs1];
   assign rDataB = (rs2 == '0) ? '0 :
                   (BYPASS && wr_ok && (rd == rs2)) ? W_data : regs[rs2];

   assign busyA = busy[rs1];
   assign busyB = busy[rs2];

   // Clear first, then set: on an issue/write-back collision the new producer keeps the bit.
   always_comb begin
      busy_nxt = busy;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         if (wr_ok)
            busy_nxt[rd] = 1'b0;
         if (iss_ok)
            busy_nxt[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      cnt_nxt = '0;
      for (int i = 1; i < NREG; i++)
         cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         busy      <= '0;
         busy_cnt  <= '0;
         check_reg <= '0;
      end else begin
         if (wr_ok)
            regs[rd] <= W_data;
         busy      <= busy_nxt;
         busy_cnt  <= cnt_nxt;
         // Debug view samples the array before this edge's write lands.
         check_reg <= (reg_checker == '0) ? '0 : regs[reg_checker];
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1, rs2, rd, issue_rd, reg_checker;
   logic        RegWrite, issue_en, flush;
   logic [31:0] W_data;
   logic [31:0] rDataA, rDataB, nb_rDataA, nb_rDataB, check_reg, nb_check_reg;
   logic        busyA, busyB, nb_busyA, nb_busyB;
   logic [5:0]  busy_cnt, nb_busy_cnt;

   logic [3:0]  p_rs1, p_rs2, p_rd, p_issue_rd, p_reg_checker;
   logic        p_RegWrite, p_issue_en, p_flush;
   logic [63:0] p_W_data, p_rDataA, p_rDataB, p_check_reg;
   logic        p_busyA, p_busyB;
   logic [4:0]  p_busy_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_sb u_dut (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rDataA(rDataA), .rDataB(rDataB),
      .busyA(busyA), .busyB(busyB), .RegWrite(RegWrite), .rd(rd), .W_data(W_data),
      .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_cnt(busy_cnt),
      .reg_checker(reg_checker), .check_reg(check_reg)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nb (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rDataA(nb_rDataA), .rDataB(nb_rDataB),
      .busyA(nb_busyA), .busyB(nb_busyB), .RegWrite(RegWrite), .rd(rd), .W_data(W_data),
      .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_cnt(nb_busy_cnt),
      .reg_checker(reg_checker), .check_reg(nb_check_reg)
   );

   regfile_sb #(.DATA_W(64), .ADDR_W(4), .BYPASS(1'b1)) u_p (
      .clk(clk), .rst_n(rst_n), .rs1(p_rs1), .rs2(p_rs2), .rDataA(p_rDataA), .rDataB(p_rDataB),
      .busyA(p_busyA), .busyB(p_busyB), .RegWrite(p_RegWrite), .rd(p_rd), .W_data(p_W_data),
      .issue_en(p_issue_en), .issue_rd(p_issue_rd), .flush(p_flush), .busy_cnt(p_busy_cnt),
      .reg_checker(p_reg_checker), .check_reg(p_check_reg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegWrite = 1'b0; rd = '0; W_data = '0;
      issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   task automatic test_reset();
      idle(); rs1 = 5'd4; rs2 = 5'd6; reg_checker = 5'd4;
      RegWrite = 1'b1; rd = 5'd4; W_data = 32'h1111_2222;
      issue_en = 1'b1; issue_rd = 5'd6;
      tick(); idle();
      checks++; if (rDataA !== 32'h1111_2222) begin failures++; $display("FAIL pre_reset_read got=%h exp=%h", rDataA, 32'h1111_2222); end
      checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=1", busy_cnt); end
      tick();
      checks++; if (check_reg !== 32'h1111_2222) begin failures++; $display("FAIL pre_reset_check got=%h exp=%h", check_reg, 32'h1111_2222); end
      RegWrite = 1'b1; rd = 5'd4; W_data = 32'h9999_9999;
      issue_en = 1'b1; issue_rd = 5'd8;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
      checks++; if (check_reg !== 32'h0) begin failures++; $display("FAIL reset_check got=%h exp=0", check_reg); end
      checks++; if (busyB !== 1'b0) begin failures++; $display("FAIL reset_busy6 got=%b exp=0", busyB); end
      tick(); idle();
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (rDataA !== 32'h0) begin failures++; $display("FAIL reset_read4 got=%h exp=0", rDataA); end
      rs2 = 5'd8;
      #1;
      checks++; if (busyB !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busyB); end
      checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt_after got=%0d exp=0", busy_cnt); end
   endtask

   task automatic test_write_bypass();
      idle(); rs1 = 5'd5; rs2 = 5'd5;
      RegWrite = 1'b1; rd = 5'd5; W_data = 32'hDEAD_BEEF;
      #1;
      checks++; if (rDataA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_a got=%h exp=%h", rDataA, 32'hDEAD_BEEF); end
      checks++; if (rDataB !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_b got=%h exp=%h", rDataB, 32'hDEAD_BEEF); end
      checks++; if (nb_rDataA !== 32'h0) begin failures++; $display("FAIL nobypass_old got=%h exp=0", nb_rDataA); end
      tick(); idle();
      checks++; if (nb_rDataA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL nobypass_new got=%h exp=%h", nb_rDataA, 32'hDEAD_BEEF); end
      checks++; if (rDataA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL array_read got=%h exp=%h", rDataA, 32'hDEAD_BEEF); end
   endtask

   task automatic test_x0();
      idle(); rs1 = 5'd0;
      RegWrite = 1'b1; rd = 5'd0; W_data = 32'h1234_5678;
      #1;
      checks++; if (rDataA !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", rDataA); end
      tick(); idle();
      issue_en = 1'b1; issue_rd = 5'd0;
      tick(); idle();
      checks++; if (rDataA !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", rDataA); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", busyA); end
      checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL x0_cnt got=%0d exp=0", busy_cnt); end
   endtask

   task automatic test_scoreboard();
      idle(); rs1 = 5'd3; rs2 = 5'd7;
      issue_en = 1'b1; issue_rd = 5'd3;
      tick(); idle();
      checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL sb_cnt1 got=%0d exp=1", busy_cnt); end
      issue_en = 1'b1; issue_rd = 5'd7;
      #1;
      checks++; if (busyB !== 1'b0) begin failures++; $display("FAIL sb_no_issue_bypass got=%b exp=0", busyB); end
      tick(); idle();
      checks++; if (busy_cnt !== 6'd2) begin failures++; $display("FAIL sb_cnt2 got=%0d exp=2", busy_cnt); end
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL sb_busy3 got=%b exp=1", busyA); end
      RegWrite = 1'b1; rd = 5'd3; W_data = 32'h33;
      #1;
      checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL sb_no_wb_bypass got=%b exp=1", busyA); end
      tick(); idle();
      checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL sb_wb_cnt got=%0d exp=1", busy_cnt); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL sb_wb_busy3 got=%b exp=0", busyA); end
      issue_en = 1'b1; issue_rd = 5'd7;
      RegWrite = 1'b1; rd = 5'd7; W_data = 32'h77;
      tick(); idle();
      checks++; if (busyB !== 1'b1) begin failures++; $display("FAIL sb_collision got=%b exp=1", busyB); end
      checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL sb_collision_cnt got=%0d exp=1", busy_cnt); end
      RegWrite = 1'b1; rd = 5'd11; W_data = 32'hB;
      tick(); idle();
      checks++; if (busy_cnt !== 6'd1) begin failures++; $display("FAIL sb_wb_nonbusy got=%0d exp=1", busy_cnt); end
   endtask

   task automatic test_flush();
      idle();
      issue_en = 1'b1; issue_rd = 5'd3; tick();
      issue_rd = 5'd9; tick(); idle();
      checks++; if (busy_cnt !== 6'd3) begin failures++; $display("FAIL flush_pre_cnt got=%0d exp=3", busy_cnt); end
      flush = 1'b1; RegWrite = 1'b1; rd = 5'd9; W_data = 32'h55;
      issue_en = 1'b1; issue_rd = 5'd12;
      tick(); idle(); rs1 = 5'd9; rs2 = 5'd12;
      #1;
      checks++; if (busy_cnt !== 6'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", busy_cnt); end
      checks++; if (rDataA !== 32'h55) begin failures++; $display("FAIL flush_write got=%h exp=55", rDataA); end
      checks++; if (busyB !== 1'b0) begin failures++; $display("FAIL flush_issue_ignored got=%b exp=0", busyB); end
   endtask

   task automatic test_debug();
      idle(); reg_checker = 5'd5;
      RegWrite = 1'b1; rd = 5'd5; W_data = 32'hAA;
      tick(); idle();
      checks++; if (check_reg !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dbg_old got=%h exp=%h", check_reg, 32'hDEAD_BEEF); end
      tick();
      checks++; if (check_reg !== 32'hAA) begin failures++; $display("FAIL dbg_new got=%h exp=aa", check_reg); end
      reg_checker = 5'd0;
      tick();
      checks++; if (check_reg !== 32'h0) begin failures++; $display("FAIL dbg_zero got=%h exp=0", check_reg); end
   endtask

   task automatic test_param();
      p_RegWrite = 1'b1; p_rd = 4'd15; p_W_data = 64'hFFFF_0000_FFFF_0000;
      tick();
      p_RegWrite = 1'b0; p_rd = '0;
      for (int i = 1; i < 16; i++) begin
         p_issue_en = 1'b1; p_issue_rd = 4'(i);
         tick();
      end
      p_issue_en = 1'b0; p_issue_rd = '0;
      p_rs1 = 4'd15; p_rs2 = 4'd0;
      #1;
      checks++; if (p_rDataA !== 64'hFFFF_0000_FFFF_0000) begin failures++; $display("FAIL p_read got=%h exp=%h", p_rDataA, 64'hFFFF_0000_FFFF_0000); end
      checks++; if (p_busy_cnt !== 5'd15) begin failures++; $display("FAIL p_cnt got=%0d exp=15", p_busy_cnt); end
      checks++; if (p_busyA !== 1'b1) begin failures++; $display("FAIL p_busy15 got=%b exp=1", p_busyA); end
      checks++; if (p_busyB !== 1'b0) begin failures++; $display("FAIL p_busy0 got=%b exp=0", p_busyB); end
      p_issue_en = 1'b1; p_issue_rd = 4'd8;
      tick(); p_issue_en = 1'b0;
      checks++; if (p_busy_cnt !== 5'd15) begin failures++; $display("FAIL p_reissue_cnt got=%0d exp=15", p_busy_cnt); end
   endtask

   initial begin
      rst_n = 1'b0; idle(); rs1 = '0; rs2 = '0; reg_checker = '0;
      p_rs1 = '0; p_rs2 = '0; p_rd = '0; p_issue_rd = '0; p_reg_checker = '0;
      p_RegWrite = 1'b0; p_issue_en = 1'b0; p_flush = 1'b0; p_W_data = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_write_bypass();
      test_x0();
      test_scoreboard();
      test_flush();
      test_debug();
      test_param();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
